dsp_mac_sequencer: RTL and testbench



---
 rtl/dsp_mac_seq_pkg.sv | 25 ++
 rtl/dsp_mac_seq_sat.sv | 49 ++++
 rtl/dsp_mac_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_seq_pkg.sv
// dsp_mac_seq_pkg: shared types and constants for the DSP MAC sequencer.
//   state_e      - sequencer FSM states
//   OPMODE_MAC   - slice OPMODE: X=M, Z=P, pre-adder bypassed, carry 0, add
//   DSP_P_W      - width of the slice P port
//   DSP_AB_W     - width of the slice A/B ports
//   state_busy() - true for every state that belongs to a job
package dsp_mac_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_LOAD  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [7:0] OPMODE_MAC = 8'b0000_1001;
   localparam int         DSP_P_W    = 48;
   localparam int         DSP_AB_W   = 18;

   function automatic logic state_busy(input state_e s);
      return (s != ST_IDLE);
   endfunction

endpackage

// File: rtl/dsp_mac_seq_sat.sv
// dsp_mac_seq_sat: converts the 48-bit slice accumulator into the RES_W-bit
// result word.
//   p_i   in  48     accumulator value from the slice P port
//   res_o out RES_W  result word
//   ovf_o out 1      set when the accumulator did not fit in RES_W bits
// Build option: DSP_MAC_SEQ_SAT_EN selects signed saturation with overflow
// flag; without it the value is truncated to its low RES_W bits and ovf_o is 0.
module dsp_mac_seq_sat
   import dsp_mac_seq_pkg::*;
#(
   parameter int RES_W = 40
) (
   input  logic [DSP_P_W-1:0] p_i,
   output logic [RES_W-1:0]   res_o,
   output logic               ovf_o
);

`ifdef DSP_MAC_SEQ_SAT_EN
   // The value fits when every bit from the result sign bit upward is a copy
   // of the sign, i.e. the top slice is all ones or all zeros.
   logic [DSP_P_W-RES_W:0] upper_s;
   logic                   fits_s;

   assign upper_s = p_i[DSP_P_W-1:RES_W-1];
   assign fits_s  = (&upper_s) | ~(|upper_s);

   // Clamp to the most positive or most negative RES_W value on overflow
   always_comb begin
      if (fits_s) begin
         res_o = p_i[RES_W-1:0];
         ovf_o = 1'b0;
      end else if (p_i[DSP_P_W-1]) begin
         res_o = {1'b1, {(RES_W-1){1'b0}}};
         ovf_o = 1'b1;
      end else begin
         res_o = {1'b0, {(RES_W-1){1'b1}}};
         ovf_o = 1'b1;
      end
   end
`else
   // Upper accumulator bits are intentionally discarded in truncation mode.
   logic unused_p_s;

   assign unused_p_s = ^p_i;
   assign res_o      = p_i[RES_W-1:0];
   assign ovf_o      = 1'b0;
`endif

endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds a dot-product job of cmd_len operand pairs into a
// DSP48A1-style slice (A1/B1/M/P/OPMODE registered, sync reset), waits out
// the slice latency and returns the accumulated P as one result beat.
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_len job request (ready only when idle)
//   s_valid/s_ready/s_a/s_b     operand pair stream (ready only while loading)
//   res_valid/res_ready         result handshake
//   res_data/res_ovf            dot product and overflow flag
//   busy                        a job is in progress
//   dsp_a/dsp_b/dsp_opmode      slice data and opcode
//   dsp_rst/dsp_ce              fanned to all slice RST*/CE* pins
//   dsp_p                       slice P output
// Build option: DSP_MAC_SEQ_SAT_EN enables result saturation (see
// dsp_mac_seq_sat); otherwise the result is truncated.
module dsp_mac_sequencer
   import dsp_mac_seq_pkg::*;
#(
   parameter int LEN_W   = 8,
   parameter int DSP_LAT = 3,
   parameter int RES_W   = 40
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [LEN_W-1:0]    cmd_len,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DSP_AB_W-1:0] s_a,
   input  logic [DSP_AB_W-1:0] s_b,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [RES_W-1:0]    res_data,
   output logic                res_ovf,
   output logic                busy,
   output logic [DSP_AB_W-1:0] dsp_a,
   output logic [DSP_AB_W-1:0] dsp_b,
   output logic [7:0]          dsp_opmode,
   output logic                dsp_rst,
   output logic                dsp_ce,
   input  logic [DSP_P_W-1:0]  dsp_p
);

   localparam int               CNT_W      = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;
   localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DSP_LAT - 1);

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    beats_left_q, beats_left_d;
   logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
   logic [RES_W-1:0]    res_data_q, res_data_d;
   logic                res_ovf_q, res_ovf_d;
   logic                cmd_ready_q;
   logic                s_ready_q;
   logic                res_valid_q;
   logic                busy_q;
   logic                dsp_rst_q;
   logic                dsp_ce_q;

   logic                s_hs_s;
   logic [RES_W-1:0]    sat_res_s;
   logic                sat_ovf_s;

   dsp_mac_seq_sat #(
      .RES_W (RES_W)
   ) u_sat (
      .p_i   (dsp_p),
      .res_o (sat_res_s),
      .ovf_o (sat_ovf_s)
   );

   // s_ready_q is only ever set in LOAD, so this is the LOAD-state handshake.
   assign s_hs_s = s_valid & s_ready_q;

   // Operands go to the slice in the acceptance cycle itself: the slice's own
   // A1/B1 stage is the first register, which is what DSP_LAT is counted from.
   // Bubbles and non-LOAD cycles present zero so the slice accumulates +0.
   always_comb begin
      if (s_hs_s) begin
         dsp_a = s_a;
         dsp_b = s_b;
      end else begin
         dsp_a = {DSP_AB_W{1'b0}};
         dsp_b = {DSP_AB_W{1'b0}};
      end
   end

   // Next-state, beat/drain counters and result capture
   always_comb begin
      state_d      = state_q;
      beats_left_d = beats_left_q;
      drain_cnt_d  = drain_cnt_q;
      res_data_d   = res_data_q;
      res_ovf_d    = res_ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               beats_left_d = cmd_len;
               state_d      = ST_CLEAR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            drain_cnt_d = DRAIN_INIT;
            if (beats_left_q == LEN_W'(0)) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (s_hs_s) begin
               beats_left_d = beats_left_q - LEN_W'(1);
               if (beats_left_q == LEN_W'(1)) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_DRAIN: begin
            // Last drain cycle: dsp_p now contains the final product.
            if (drain_cnt_q == CNT_W'(0)) begin
               res_data_d = sat_res_s;
               res_ovf_d  = sat_ovf_s;
               state_d    = ST_DONE;
            end else begin
               drain_cnt_d = drain_cnt_q - CNT_W'(1);
               state_d     = ST_DRAIN;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters, result and control outputs decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         beats_left_q <= LEN_W'(0);
         drain_cnt_q  <= CNT_W'(0);
         res_data_q   <= RES_W'(0);
         res_ovf_q    <= 1'b0;
         cmd_ready_q  <= 1'b1;
         s_ready_q    <= 1'b0;
         res_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         dsp_rst_q    <= 1'b0;
         dsp_ce_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         beats_left_q <= beats_left_d;
         drain_cnt_q  <= drain_cnt_d;
         res_data_q   <= res_data_d;
         res_ovf_q    <= res_ovf_d;
         cmd_ready_q  <= (state_d == ST_IDLE);
         s_ready_q    <= (state_d == ST_LOAD) && (beats_left_d != LEN_W'(0));
         res_valid_q  <= (state_d == ST_DONE);
         busy_q       <= state_busy(state_d);
         dsp_rst_q    <= (state_d == ST_CLEAR);
         // DONE drops CE so the slice holds P while the result waits.
         dsp_ce_q     <= (state_d == ST_CLEAR) || (state_d == ST_LOAD) ||
                         (state_d == ST_DRAIN);
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign s_ready    = s_ready_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_ovf    = res_ovf_q;
   assign busy       = busy_q;
   assign dsp_rst    = dsp_rst_q;
   assign dsp_ce     = dsp_ce_q;
   assign dsp_opmode = OPMODE_MAC;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural stand-in for the DSP slice,
// a dot-product/timing model of the job, and directed jobs.
module tb_dsp_mac_sequencer;

   localparam int     LEN_W   = 8;
   localparam int     DSP_LAT = 3;
   localparam int     RES_W   = 40;
   localparam longint RES_MAX = (longint'(1) <<< (RES_W - 1)) - 1;
   localparam longint RES_MIN = -(longint'(1) <<< (RES_W - 1));

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid, cmd_ready, s_valid, s_ready;
   logic [LEN_W-1:0] cmd_len;
   logic [17:0]      s_a, s_b, dsp_a, dsp_b;
   logic             res_valid, res_ready, res_ovf, busy, dsp_rst, dsp_ce;
   logic [RES_W-1:0] res_data;
   logic [7:0]       dsp_opmode;
   logic [47:0]      dsp_p;

   always #5 clk = ~clk;

   dsp_mac_sequencer #(.LEN_W(LEN_W), .DSP_LAT(DSP_LAT), .RES_W(RES_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_ovf(res_ovf), .busy(busy),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
      .dsp_rst(dsp_rst), .dsp_ce(dsp_ce), .dsp_p(dsp_p)
   );

   // Slice stand-in: A1/B1 -> M -> P with registered OPMODE, sync reset, CE.
   logic signed [17:0] a1_q = '0, b1_q = '0;
   logic signed [35:0] m_q = '0;
   logic [47:0]        p_q = '0;
   logic [7:0]         op_q = '0;
   logic [47:0]        slice_x, slice_z;

   assign slice_x = (op_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0;
   assign slice_z = (op_q[3:2] == 2'b10) ? p_q : 48'd0;
   assign dsp_p   = p_q;

   always @(posedge clk) begin
      if (dsp_rst) begin
         a1_q <= '0; b1_q <= '0; m_q <= '0; p_q <= '0; op_q <= '0;
      end else if (dsp_ce) begin
         a1_q <= dsp_a;
         b1_q <= dsp_b;
         m_q  <= a1_q * b1_q;
         op_q <= dsp_opmode;
         p_q  <= slice_z + slice_x;
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no handshake within the cycle budget (cycle %0d)", name, cyc);
   endtask

   // Job model: what the outputs must be, from the pairs and the job timing.
   logic signed [17:0] pa [0:255];
   logic signed [17:0] pb [0:255];
   bit                 job_active = 1'b0;
   int                 hs_edge = 0;
   int                 exp_lat = 0;
   logic [RES_W-1:0]   exp_res = '0;
   logic               exp_ovf = 1'b0;
   bit                 exp_rv, exp_ce, exp_rst;

   task automatic model_job(input int n);
      longint sum;
      longint p48;
      sum = 0;
      for (int i = 0; i < n; i++) sum += longint'(pa[i]) * longint'(pb[i]);
      p48 = (sum <<< 16) >>> 16;
`ifdef DSP_MAC_SEQ_SAT_EN
      if (p48 > RES_MAX) begin
         exp_res = RES_W'(RES_MAX); exp_ovf = 1'b1;
      end else if (p48 < RES_MIN) begin
         exp_res = RES_W'(RES_MIN); exp_ovf = 1'b1;
      end else begin
         exp_res = RES_W'(p48); exp_ovf = 1'b0;
      end
`else
      exp_res = RES_W'(p48);
      exp_ovf = 1'b0;
`endif
   endtask

   // Compare process: every cycle out of reset, DUT against the job model.
   always @(negedge clk) begin
      if (rst_n) begin
         exp_rv  = job_active && (cyc >= hs_edge + exp_lat - 1);
         exp_ce  = job_active && (cyc <  hs_edge + exp_lat - 1);
         exp_rst = job_active && (cyc == hs_edge);
         check("cmd_ready", 64'(cmd_ready), 64'(!job_active));
         check("busy", 64'(busy), 64'(job_active));
         check("res_valid", 64'(res_valid), 64'(exp_rv));
         check("dsp_ce", 64'(dsp_ce), 64'(exp_ce));
         check("dsp_rst", 64'(dsp_rst), 64'(exp_rst));
         check("dsp_opmode", 64'(dsp_opmode), 64'(8'h09));
         if (!job_active || exp_rst || exp_rv) check("s_ready_off", 64'(s_ready), 64'd0);
         if (exp_rv) begin
            check("res_data", 64'(res_data), 64'(exp_res));
            check("res_ovf", 64'(res_ovf), 64'(exp_ovf));
         end
      end
   end

   task automatic send_cmd(input int n);
      bit ok;
      ok = 1'b0;
      cmd_valid = 1'b1;
      cmd_len = n[LEN_W-1:0];
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         timeout("cmd_handshake");
         cmd_valid = 1'b0;
         return;
      end
      hs_edge = cyc + 1;
      @(posedge clk);
      job_active = 1'b1;
      #1;
      cmd_valid = 1'b0;
      cmd_len = '0;
   endtask

   task automatic send_beats(input int n, input int bub_at, input int bub_n);
      bit ok;
      for (int i = 0; i < n; i++) begin
         if (i == bub_at && bub_n > 0) begin
            s_valid = 1'b0;
            repeat (bub_n) @(posedge clk);
            #1;
         end
         s_valid = 1'b1; s_a = pa[i]; s_b = pb[i];
         ok = 1'b0;
         for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
         end
         if (!ok) begin
            timeout("s_handshake");
            break;
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0; s_a = '0; s_b = '0;
   endtask

   task automatic consume(input int budget, input int hold, input logic [RES_W-1:0] lit_res,
                          input logic lit_ovf, input int lit_lat, input string name);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         if (res_valid) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         timeout({name, "_result"});
         job_active = 1'b0;
         return;
      end
      check({name, "_latency"}, 64'(cyc - hs_edge + 1), 64'(lit_lat));
      check({name, "_data"}, 64'(res_data), 64'(lit_res));
      check({name, "_ovf"}, 64'(res_ovf), 64'(lit_ovf));
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(posedge clk);
      job_active = 1'b0;
      #1;
      res_ready = 1'b0;
   endtask

   task automatic run_job(input int n, input int bub_at, input int bub_n, input int hold,
                          input logic [RES_W-1:0] lit_res, input logic lit_ovf,
                          input int lit_lat, input string name);
      model_job(n);
      exp_lat = n + bub_n + DSP_LAT + 2;
      send_cmd(n);
      send_beats(n, bub_at, bub_n);
      consume(n + bub_n + 64, hold, lit_res, lit_ovf, lit_lat, name);
   endtask

   task automatic set_pair(input int i, input int a, input int b);
      pa[i] = 18'(a);
      pb[i] = 18'(b);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_valid = 1'b0; cmd_len = '0; s_valid = 1'b0; s_a = '0; s_b = '0; res_ready = 1'b0;

      // Reset held while inputs toggle randomly.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_len   = LEN_W'($urandom);
         s_valid   = 1'($urandom_range(0, 1));
         s_a       = 18'($urandom);
         s_b       = 18'($urandom);
         res_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("rst_res_valid", 64'(res_valid), 64'd0);
         check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_dsp_rst", 64'(dsp_rst), 64'd0);
         check("rst_dsp_ce", 64'(dsp_ce), 64'd0);
         check("rst_dsp_a", 64'(dsp_a), 64'd0);
         check("rst_opmode", 64'(dsp_opmode), 64'(8'h09));
      end
      cmd_valid = 1'b0; cmd_len = '0; s_valid = 1'b0; s_a = '0; s_b = '0; res_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      set_pair(0, 20, 10); set_pair(1, 5, 6); set_pair(2, -3, 7); set_pair(3, 100, 100);
      run_job(4, -1, 0, 0, 40'd10209, 1'b0, 9, "len4");
      run_job(4, 2, 2, 0, 40'd10209, 1'b0, 11, "len4_bubbles");
      run_job(0, -1, 0, 10, 40'd0, 1'b0, 5, "len0_hold");

      set_pair(0, -7, 9); set_pair(1, 131071, 2); set_pair(2, -131072, 1);
      run_job(3, 1, 1, 0, 40'd131007, 1'b0, 9, "len3_mixed");

      for (int i = 0; i < 255; i++) set_pair(i, -131072, -131072);
`ifdef DSP_MAC_SEQ_SAT_EN
      run_job(255, -1, 0, 0, 40'h7F_FFFF_FFFF, 1'b1, 260, "len255_sat");
`else
      run_job(255, -1, 0, 0, 40'hFC_0000_0000, 1'b0, 260, "len255_trunc");
`endif

      // Abort during LOAD, then a fresh job must show no residue.
      for (int i = 0; i < 4; i++) set_pair(i, 1000, 1000);
      model_job(4);
      exp_lat = 4 + DSP_LAT + 2;
      send_cmd(4);
      send_beats(2, -1, 0);
      rst_n = 1'b0;
      job_active = 1'b0;
      @(negedge clk);
      check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_s_ready", 64'(s_ready), 64'd0);
      check("abort_dsp_ce", 64'(dsp_ce), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      set_pair(0, 3, 4);
      run_job(1, -1, 0, 0, 40'd12, 1'b0, 6, "after_abort");

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
